mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus, beside dmem; consumes the store stream (memwrite, dataadr, writedata) leaving the CPU top.
- Stores to its data address queue a byte in a small FIFO. A serial FSM shifts queued bytes out on txd as 8N1 frames.
- A status word is returned combinationally for the load-data mux in front of the CPU's readdata.

Parameters:
- ADDR_DATA, 32'h1000_0000, byte-write (TX data) register address.
- ADDR_STATUS, 32'h1000_0004, status/control register address.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memwrite  in  1  store strobe from the CPU.
- dataadr  in  32  store/load address from the CPU.
- writedata  in  32  store data from the CPU.
- sel  out  1  combinational; 1 when dataadr == ADDR_DATA or ADDR_STATUS (drives the readdata mux).
- status_rdata  out  32  combinational status word.
- txd  out  1  serial output; idle high; registered.
- irq_empty  out  1  registered; 1 when the FIFO is empty and the FSM is IDLE.

Behaviour:
- Reset: txd=1, irq_empty=1, FIFO empty (pointers 0, count 0), overflow=0, FSM=IDLE, bit counter=0, baud counter=0. Reset mid-frame aborts the frame: txd=1 on the next cycle and queued data is discarded.
- Push:
  - When memwrite && dataadr==ADDR_DATA, writedata[7:0] is written at the edge; upper bits are ignored.
  - If the registered count == FIFO_DEPTH at that edge, the byte is dropped and overflow is set (sticky). This holds even if a pop occurs in the same cycle.
- Status/control:
  - When memwrite && dataadr==ADDR_STATUS && writedata[0]==1, overflow is cleared.
  - A simultaneous overflow-set is impossible, because the two addresses differ.
- status_rdata = {27'b0, parity_en, overflow, full, empty, busy}.
  - busy = FSM != IDLE.
  - full and empty come from the registered count.
  - parity_en is a constant (see Optional Feature).
- Pointers: rd/wr pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
  - IDLE: if FIFO not empty → pop into the shift register, go to START, txd<=0, baud=0.
  - START: hold txd=0 for CLKS_PER_BIT cycles → DATA, txd<=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 → STOP (or PARITY), txd<=1 (or parity).
  - STOP: hold txd=1 for CLKS_PER_BIT cycles. At the end, if FIFO not empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: a store at edge N to an empty, idle block drives txd low after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back start edges are 10*CLKS_PER_BIT apart.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; the state/bit advances on wrap.
- irq_empty is updated every edge from the next-state empty && next-state IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT, and status bit 4 reads 1.
- Undefined: no PARITY state, 10-bit frames, status bit 4 reads 0.

Decomposition:
- Shared package (uart_pkg):
  - FSM state enum typedef.
  - Status bit-index constants (BUSY=0, EMPTY=1, FULL=2, OVF=3, PAR=4).
  - Default MMIO base-address constants, alongside consts.v macros.
- Sub-module: sync_fifo, parameterised by width and depth, with push/pop/full/empty/count. The FSM and decode stay in mmio_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Single byte: store 32'hFFFF_FF55 to ADDR_DATA → txd low after the next edge. Sampled bits (mid-bit) read 0,1,0,1,0,1,0,1,0,1 (start, 8'h55 LSB-first, stop). busy=1 for 40 cycles, then irq_empty=1.
- Back-to-back: store 8'hA5 then 8'h3C on consecutive cycles → two frames; second start edge exactly 40 cycles after the first; no extra idle cycle.
- Overflow: 10 stores in consecutive cycles → first byte popped to TX, 8 queued, 10th dropped. Status reads 32'h0000_000D (overflow, full, busy). Store 1 to ADDR_STATUS → overflow=0. Bytes 1–9 transmitted in order.
- Address decode: store to ADDR_DATA+8 and load from ADDR_STATUS → no push, sel=0 for the store; sel=1 and status=32'h2 for the load when idle.
- Reset mid-frame: assert reset during data bit 3 with 2 bytes queued → next cycle txd=1, status=32'h2, no further frames.
- Parity (UART_TX_PARITY_EN): send 8'h07 → parity bit 1, frame 44 cycles, status bit 4 = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit state to the serial FSM.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_e;
    localparam logic PARITY_EN = 1'b1;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} tx_state_e;
    localparam logic PARITY_EN = 1'b0;
`endif

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_FULL  = 2;
    localparam int unsigned STAT_OVF   = 3;
    localparam int unsigned STAT_PAR   = 4;

    localparam logic [31:0] UART_ADDR_DATA   = 32'h1000_0000;
    localparam logic [31:0] UART_ADDR_STATUS = 32'h1000_0004;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and status register.
// Define UART_TX_PARITY_EN for an even-parity bit (8E1 frames).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] ADDR_DATA    = UART_ADDR_DATA,
    parameter logic [31:0] ADDR_STATUS  = UART_ADDR_STATUS,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        sel,
    output logic [31:0] status_rdata,
    output logic        txd,
    output logic        irq_empty
);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;

    logic          hit_data, hit_status, push_req, push_ok, pop, baud_wrap;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count, count_next;

    assign hit_data   = (dataadr == ADDR_DATA);
    assign hit_status = (dataadr == ADDR_STATUS);
    assign sel        = hit_data || hit_status;
    assign push_req   = memwrite && hit_data;
    assign push_ok    = push_req && !fifo_full;
    assign baud_wrap  = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign txd        = txd_q;
    assign irq_empty  = irq_q;

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i (writedata[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status_rdata             = '0;
        status_rdata[STAT_BUSY]  = (state_q != StIdle);
        status_rdata[STAT_EMPTY] = fifo_empty;
        status_rdata[STAT_FULL]  = fifo_full;
        status_rdata[STAT_OVF]   = ovf_q;
        status_rdata[STAT_PAR]   = PARITY_EN;
    end

    always_comb begin
        ovf_d = ovf_q;
        if (push_req && fifo_full) begin
            ovf_d = 1'b1;
        end else if (memwrite && hit_status && writedata[0]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        if (state_q != StIdle) baud_d = baud_wrap ? '0 : baud_q + BW'(1);
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    par_d   = ^fifo_rdata;
                    state_d = StStart;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (baud_wrap) begin
                    state_d = StData;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            StData: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        txd_d   = par_q;
`else
                        state_d = StStop;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_wrap) begin
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end
`endif
            StStop: begin
                if (baud_wrap) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        par_d   = ^fifo_rdata;
                        state_d = StStart;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign count_next = fifo_count + CW'(push_ok) - CW'(pop);
    assign irq_d      = (count_next == '0) && (state_d == StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a serial monitor decodes txd frames and checks them
// against bytes queued by the stimulus; directed checks cover status, decode and reset.
module tb_mmio_uart_tx;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] A_DATA = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int unsigned FRAME = (PAR_EN ? 11 : 10) * CPB;
    localparam logic [31:0] PARB  = PAR_EN ? 32'h10 : 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        sel, txd, irq_empty;
    logic [31:0] status_rdata;

    int          nchk = 0;
    int          nfail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    mmio_uart_tx #(
        .ADDR_DATA    (A_DATA),
        .ADDR_STATUS  (A_STAT),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .sel          (sel),
        .status_rdata (status_rdata),
        .txd          (txd),
        .irq_empty    (irq_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        step();
        memwrite  = 1'b0;
        dataadr   = '0;
    endtask

    task automatic send(input logic [7:0] b, input logic [23:0] junk);
        exp_q.push_back(b);
        store(A_DATA, {junk, b});
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!irq_empty && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'b0, irq_empty}, 32'h1);
    endtask

    task automatic read_status(output logic [31:0] s, output logic sl);
        dataadr = A_STAT;
        #1;
        s  = status_rdata;
        sl = sel;
        dataadr = '0;
    endtask

    // Serial monitor: decode each frame at mid-bit and compare with the scoreboard.
    initial begin : monitor
        logic       prev;
        logic [7:0] got;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && prev && !txd) begin
                start_q.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                chk("start_bit", {31'b0, txd}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = txd;
                end
                if (PAR_EN) begin
                    repeat (CPB) @(negedge clk);
                    chk("parity_bit", {31'b0, txd}, {31'b0, ^got});
                end
                repeat (CPB) @(negedge clk);
                chk("stop_bit", {31'b0, txd}, 32'h1);
                if (exp_q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_frame: got %h expected none", got);
                end else begin
                    chk("frame_data", {24'b0, got}, {24'b0, exp_q.pop_front()});
                end
            end
            prev = txd;
        end
    end

    initial begin
        logic [31:0] s;
        logic        sl;
        int          n;
        int          falls;
        logic        p;
        logic [7:0]  b;

        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        chk("reset_txd", {31'b0, txd}, 32'h1);
        chk("reset_irq", {31'b0, irq_empty}, 32'h1);
        read_status(s, sl);
        chk("reset_status", s, 32'h2 | PARB);
        chk("reset_sel", {31'b0, sl}, 32'h1);

        // Single byte: latency and busy duration
        send(8'h55, 24'hFFFFFF);
        chk("latency_pre", {31'b0, txd}, 32'h1);
        step();
        chk("latency_low", {31'b0, txd}, 32'h0);
        n = 0;
        dataadr = A_STAT;
        #1;
        while (status_rdata[0] && n < 4 * FRAME) begin
            step();
            n++;
        end
        dataadr = '0;
        chk("busy_cycles", n, FRAME);
        chk("irq_after", {31'b0, irq_empty}, 32'h1);
        wait_idle(4 * FRAME);

        // Back-to-back frames
        start_q.delete();
        send(8'hA5, 24'h0);
        send(8'h3C, 24'h123456);
        wait_idle(4 * FRAME);
        chk("b2b_frames", start_q.size(), 2);
        if (start_q.size() == 2) chk("b2b_spacing", start_q[1] - start_q[0], FRAME);

        // Overflow: first byte goes straight to the shifter, 8 queue, 10th drops
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if (i < 9) exp_q.push_back(b);
            store(A_DATA, {8'($urandom), 16'h0, b});
        end
        read_status(s, sl);
        chk("ovf_status", s, 32'hD | PARB);
        store(A_STAT, 32'h1);
        read_status(s, sl);
        chk("ovf_clear", s, 32'h5 | PARB);
        wait_idle(12 * FRAME);
        chk("ovf_drained", exp_q.size(), 0);

        // Address decode: non-matching store, then a status load
        memwrite  = 1'b1;
        dataadr   = A_DATA + 32'h8;
        writedata = 32'h77;
        #1;
        chk("decode_sel_store", {31'b0, sel}, 32'h0);
        step();
        memwrite = 1'b0;
        chk("decode_no_push", {31'b0, irq_empty}, 32'h1);
        read_status(s, sl);
        chk("decode_sel_load", {31'b0, sl}, 32'h1);
        chk("decode_status", s, 32'h2 | PARB);

        // Reset during data bit 3 with two bytes queued
        mon_en = 1'b0;
        store(A_DATA, 32'h00);
        store(A_DATA, 32'h11);
        store(A_DATA, 32'h22);
        repeat (15) step();
        chk("pre_reset_low", {31'b0, txd}, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_txd", {31'b0, txd}, 32'h1);
        chk("rst_irq", {31'b0, irq_empty}, 32'h1);
        read_status(s, sl);
        chk("rst_status", s, 32'h2 | PARB);
        falls = 0;
        p = txd;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (p && !txd) falls++;
            p = txd;
        end
        chk("rst_no_frames", falls, 0);
        mon_en = 1'b1;

        // Parity-sensitive byte, then randomized bursts with decode noise
        send(8'h07, 24'h0);
        wait_idle(4 * FRAME);
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    store(A_DATA + 32'(4 * $urandom_range(2, 5)), $urandom);
                send(8'($urandom), 24'($urandom));
                repeat ($urandom_range(0, 2)) step();
            end
            wait_idle((DEPTH + 3) * FRAME);
        end
        read_status(s, sl);
        chk("final_status", s, 32'h2 | PARB);
        chk("final_scoreboard", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
